// File: rtl/pipe_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_issue_ctrl_if
// Bundles the request, issue, retire, drain and statistics signals of the
// issue controller.
//   master : requester / pipeline side (drives in_*, drain_req)
//   slave  : the controller (drives in_ready, iss_*, retire_*, busy,
//            drain_done, issue_cnt, stall_cnt)
// CNT_W must match the CNT_W of the attached pipe_issue_ctrl.
// ---------------------------------------------------------------------------
interface pipe_issue_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_rs1;
  logic [3:0]       in_rs2;
  logic [3:0]       in_rd;
  logic [1:0]       in_func;
  logic [7:0]       in_addr;
  logic             iss_valid;
  logic [3:0]       iss_rs1;
  logic [3:0]       iss_rs2;
  logic [3:0]       iss_rd;
  logic [1:0]       iss_func;
  logic [7:0]       iss_addr;
  logic             drain_req;
  logic             drain_done;
  logic             retire_valid;
  logic [3:0]       retire_rd;
  logic             busy;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, drain_req,
    input  in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr,
    input  drain_done, retire_valid, retire_rd, busy, issue_cnt, stall_cnt
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, drain_req,
    output in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr,
    output drain_done, retire_valid, retire_rd, busy, issue_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_issue_ctrl
// In-order issue controller with a shift-register scoreboard. An op is
// accepted when no in-flight destination matches one of its sources (RAW),
// issued one cycle later, and retired DEPTH cycles after acceptance.
// drain_req stops issue until the scoreboard is empty, then drain_done
// pulses once.
// Ports:
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : pipe_issue_ctrl_if.slave (handshake, issue, retire, drain, counters)
// ---------------------------------------------------------------------------
module pipe_issue_ctrl #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [DEPTH-1:0][3:0]  rd_q, rd_d;
  logic                   iss_valid_q;
  logic [3:0]             iss_rs1_q, iss_rs2_q, iss_rd_q;
  logic [1:0]             iss_func_q;
  logic [7:0]             iss_addr_q;
  logic                   drain_done_q, drain_done_d;
  logic [CNT_W-1:0]       issue_cnt_q, stall_cnt_q;
  logic                   hazard_s, ready_s, accept_s, busy_s;

  // RAW hazard: any valid slot (retiring slot included) writes a source
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && ((rd_q[i] == bus.in_rs1) || (rd_q[i] == bus.in_rs2))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  assign busy_s   = |vld_q;
  // drain_req blocks acceptance in the same cycle it is raised
  assign ready_s  = ~rst & (state_q != S_DRAIN) & ~bus.drain_req & ~hazard_s;
  assign accept_s = bus.in_valid & ready_s;

  // Scoreboard shift: new entry enters slot 0 every cycle, valid only on accept
  always_comb begin
    vld_d    = '0;
    rd_d     = '0;
    vld_d[0] = accept_s;
    rd_d[0]  = bus.in_rd;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      rd_d[i]  = rd_q[i-1];
    end
  end

  // FSM next state; drain_done is pre-computed so the registered pulse lines
  // up with the cycle in which DRAIN sees an empty scoreboard
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.drain_req) begin
          state_d = S_DRAIN;
        end else if (accept_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.drain_req) begin
          state_d = S_DRAIN;
        end else if (!busy_s && !accept_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!busy_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    drain_done_d = (state_d == S_DRAIN) && !(|vld_d);
  end

  // State, scoreboard, issue register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vld_q        <= '0;
      rd_q         <= '0;
      iss_valid_q  <= 1'b0;
      iss_rs1_q    <= 4'd0;
      iss_rs2_q    <= 4'd0;
      iss_rd_q     <= 4'd0;
      iss_func_q   <= 2'd0;
      iss_addr_q   <= 8'd0;
      drain_done_q <= 1'b0;
      issue_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      rd_q         <= rd_d;
      iss_valid_q  <= accept_s;
      drain_done_q <= drain_done_d;
      if (accept_s) begin
        iss_rs1_q   <= bus.in_rs1;
        iss_rs2_q   <= bus.in_rs2;
        iss_rd_q    <= bus.in_rd;
        iss_func_q  <= bus.in_func;
        iss_addr_q  <= bus.in_addr;
        issue_cnt_q <= issue_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        issue_cnt_q <= issue_cnt_q;
      end
      if (bus.in_valid && !ready_s) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign bus.in_ready     = ready_s;
  assign bus.iss_valid    = iss_valid_q;
  assign bus.iss_rs1      = iss_rs1_q;
  assign bus.iss_rs2      = iss_rs2_q;
  assign bus.iss_rd       = iss_rd_q;
  assign bus.iss_func     = iss_func_q;
  assign bus.iss_addr     = iss_addr_q;
  assign bus.drain_done   = drain_done_q;
  assign bus.retire_valid = vld_q[DEPTH-1];
  assign bus.retire_rd    = rd_q[DEPTH-1];
  assign bus.busy         = busy_s;
  assign bus.issue_cnt    = issue_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_issue_ctrl
// Directed scenarios plus randomized traffic against a reference model that
// keeps a list of accepted ops with their acceptance cycle. CNT_W is 4 so
// counter wrap is exercised often.
// ---------------------------------------------------------------------------
module tb_pipe_issue_ctrl;
  localparam int DEPTH = 3;
  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         c;
    logic [3:0] rd;
  } fl_t;

  fl_t         fl_q[$];
  int          cyc        = 0;
  bit          draining   = 1'b0;
  int          exp_issue  = 0;
  int          exp_stall  = 0;
  logic [21:0] last_op    = '0;
  int          last_acc   = -100;
  bit          live       = 1'b0;
  int          n_checks   = 0;
  int          n_errors   = 0;
  logic        obs_ready;
  logic        obs_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // compare this cycle's outputs to the model, then advance the model
  task automatic eval_cycle();
    bit         m_busy, m_haz, m_ret, m_rdy, m_done, m_iv;
    logic [3:0] m_ret_rd;
    int         age;
    fl_t        ent;
    m_busy = 1'b0; m_haz = 1'b0; m_ret = 1'b0; m_ret_rd = 4'd0;
    foreach (fl_q[i]) begin
      age = cyc - fl_q[i].c;
      if (age >= 1 && age <= DEPTH) begin
        m_busy = 1'b1;
        if (fl_q[i].rd == bus.in_rs1 || fl_q[i].rd == bus.in_rs2) m_haz = 1'b1;
        if (age == DEPTH) begin
          m_ret    = 1'b1;
          m_ret_rd = fl_q[i].rd;
        end
      end
    end
    m_rdy  = !rst && !draining && !bus.drain_req && !m_haz;
    m_done = draining && !m_busy;
    m_iv   = (last_acc == cyc - 1);
    if (live) begin
      chk("in_ready",     {31'd0, bus.in_ready},     {31'd0, m_rdy});
      chk("iss_valid",    {31'd0, bus.iss_valid},    {31'd0, m_iv});
      chk("iss_fields",   {10'd0, bus.iss_rs1, bus.iss_rs2, bus.iss_rd, bus.iss_func, bus.iss_addr},
                          {10'd0, last_op});
      chk("retire_valid", {31'd0, bus.retire_valid}, {31'd0, m_ret});
      if (m_ret) chk("retire_rd", {28'd0, bus.retire_rd}, {28'd0, m_ret_rd});
      chk("busy",         {31'd0, bus.busy},         {31'd0, m_busy});
      chk("drain_done",   {31'd0, bus.drain_done},   {31'd0, m_done});
      chk("issue_cnt",    {28'd0, bus.issue_cnt},    exp_issue);
      chk("stall_cnt",    {28'd0, bus.stall_cnt},    exp_stall);
    end
    if (rst) begin
      fl_q.delete();
      draining  = 1'b0;
      exp_issue = 0;
      exp_stall = 0;
      last_op   = '0;
      last_acc  = -100;
    end else begin
      while (fl_q.size() > 0 && (cyc - fl_q[0].c) >= DEPTH) void'(fl_q.pop_front());
      if (bus.in_valid && m_rdy) begin
        ent.c  = cyc;
        ent.rd = bus.in_rd;
        fl_q.push_back(ent);
        last_op   = {bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_func, bus.in_addr};
        last_acc  = cyc;
        exp_issue = (exp_issue + 1) % CMOD;
      end else if (bus.in_valid) begin
        exp_stall = (exp_stall + 1) % CMOD;
      end
      draining = draining ? m_busy : bus.drain_req;
    end
    cyc++;
  endtask

  task automatic op(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                    input logic [3:0] rd, input logic [1:0] fn, input logic [7:0] ad,
                    input logic dr, input logic r);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    bus.in_func   = fn;
    bus.in_addr   = ad;
    bus.drain_req = dr;
    rst           = r;
    #1;
    obs_ready = bus.in_ready;
    obs_done  = bus.drain_done;
    eval_cycle();
  endtask

  task automatic idle();
    op(1'b0, 4'd15, 4'd15, 4'd0, 2'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    op(1'b0, 4'd15, 4'd15, 4'd0, 2'd0, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int  stalls, pulses, done_at, ready_at;
    bit  got;
    bus.in_valid = 1'b0; bus.in_rs1 = 4'd0; bus.in_rs2 = 4'd0; bus.in_rd = 4'd0;
    bus.in_func = 2'd0; bus.in_addr = 8'd0; bus.drain_req = 1'b0;

    do_reset();
    live = 1'b1;
    do_reset();
    idle();

    // single op: issue next cycle, retire DEPTH cycles after accept
    op(1'b1, 4'd1, 4'd2, 4'd3, 2'd0, 8'h10, 1'b0, 1'b0);
    chk("r032_ready", {31'd0, obs_ready}, 32'd1);
    idle();
    chk("r032_iss_valid", {31'd0, bus.iss_valid}, 32'd1);
    chk("r032_iss_rd", {28'd0, bus.iss_rd}, 32'd3);
    chk("r032_iss_addr", {24'd0, bus.iss_addr}, 32'h10);
    idle();
    chk("r032_no_early_retire", {31'd0, bus.retire_valid}, 32'd0);
    idle();
    chk("r032_retire_valid", {31'd0, bus.retire_valid}, 32'd1);
    chk("r032_retire_rd", {28'd0, bus.retire_rd}, 32'd3);
    idle();

    // RAW dependency stalls for DEPTH cycles
    do_reset();
    op(1'b1, 4'd1, 4'd2, 4'd5, 2'd0, 8'h20, 1'b0, 1'b0);
    stalls = 0; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      op(1'b1, 4'd5, 4'd6, 4'd7, 2'd1, 8'h21, 1'b0, 1'b0);
      if (obs_ready) got = 1'b1;
      else stalls++;
    end
    chk("r033_accepted", {31'd0, got}, 32'd1);
    chk("r033_stalls", stalls, 32'd3);
    idle();
    chk("r033_issue_cnt", {28'd0, bus.issue_cnt}, 32'd2);
    chk("r033_stall_cnt", {28'd0, bus.stall_cnt}, 32'd3);

    // WAW only: same rd in flight, no source match, no stall
    do_reset();
    op(1'b1, 4'd1, 4'd2, 4'd9, 2'd2, 8'h30, 1'b0, 1'b0);
    op(1'b1, 4'd3, 4'd4, 4'd9, 2'd3, 8'h31, 1'b0, 1'b0);
    chk("waw_no_stall", {31'd0, obs_ready}, 32'd1);

    // independent stream of 10 ops
    do_reset();
    for (int i = 0; i < 10; i++)
      op(1'b1, 4'(8 + (i % 4)), 4'(12 + (i % 4)), 4'(i % 8), 2'(i % 4), 8'(i), 1'b0, 1'b0);
    idle();
    chk("r034_stall_cnt", {28'd0, bus.stall_cnt}, 32'd0);
    chk("r034_issue_cnt", {28'd0, bus.issue_cnt}, 32'd10);

    // drain with in_valid in the same cycle, 2 ops in flight
    do_reset();
    op(1'b1, 4'd9, 4'd10, 4'd1, 2'd0, 8'h40, 1'b0, 1'b0);
    op(1'b1, 4'd9, 4'd10, 4'd2, 2'd0, 8'h41, 1'b0, 1'b0);
    op(1'b1, 4'd9, 4'd10, 4'd4, 2'd0, 8'h42, 1'b1, 1'b0);
    chk("r035_no_accept", {31'd0, obs_ready}, 32'd0);
    pulses = 0; done_at = -1; ready_at = -1;
    for (int k = 0; k < 10; k++) begin
      op(1'b1, 4'd9, 4'd10, 4'd3, 2'd0, 8'h43, 1'b0, 1'b0);
      if (obs_done) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      if (obs_ready && ready_at < 0) ready_at = k;
    end
    chk("r035_pulses", pulses, 32'd1);
    chk("r035_done_seen", {31'd0, (done_at >= 0)}, 32'd1);
    chk("r035_ready_after_done", ready_at, done_at + 1);

    // drain from IDLE with empty scoreboard: done on the next cycle
    do_reset();
    idle();
    op(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 8'd0, 1'b1, 1'b0);
    idle();
    chk("r026_done_next", {31'd0, obs_done}, 32'd1);
    idle();

    // reset with 3 ops in flight
    do_reset();
    op(1'b1, 4'd8, 4'd9, 4'd1, 2'd0, 8'h50, 1'b0, 1'b0);
    op(1'b1, 4'd8, 4'd9, 4'd2, 2'd0, 8'h51, 1'b0, 1'b0);
    op(1'b1, 4'd8, 4'd9, 4'd3, 2'd0, 8'h52, 1'b0, 1'b0);
    op(1'b1, 4'd8, 4'd9, 4'd4, 2'd0, 8'h53, 1'b0, 1'b1);
    chk("r031_ready_in_rst", {31'd0, obs_ready}, 32'd0);
    idle();
    chk("r036_busy", {31'd0, bus.busy}, 32'd0);
    chk("r036_retire", {31'd0, bus.retire_valid}, 32'd0);
    chk("r036_issue_cnt", {28'd0, bus.issue_cnt}, 32'd0);
    chk("r036_stall_cnt", {28'd0, bus.stall_cnt}, 32'd0);

    // counter wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 17; i++)
      op(1'b1, 4'(8 + (i % 4)), 4'(12 + (i % 4)), 4'(i % 8), 2'(i % 4), 8'(i), 1'b0, 1'b0);
    idle();
    chk("r037_wrap", {28'd0, bus.issue_cnt}, 32'd1);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      op(1'($urandom_range(0, 9) < 7),
         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
         2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
         1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 199) == 0));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
